// File: rtl/simple_processor.sv
// simple_processor: multi-cycle 32-bit MIPS-style core with a 32x32 register
// file and an external synchronous 4096x32 SRAM port (active-low write enable).
// Optional feature: define SP_MULT_EN to enable R-type funct 0x08 (mult);
// without it that funct decodes as a NOP.
module simple_processor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] inst,
    input  logic [31:0] mem_dout,
    output logic        out_valid,
    output logic [31:0] inst_addr,
    output logic        mem_wen,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [31:0] inst_q;
    logic [31:0] pc;
    logic [31:0] r [0:31];

    // Instruction fields of the latched word
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;

    assign opcode = inst_q[31:26];
    assign rs     = inst_q[25:21];
    assign rt     = inst_q[20:16];
    assign rd     = inst_q[15:11];
    assign shamt  = inst_q[10:6];
    assign funct  = inst_q[5:0];
    assign imm    = inst_q[15:0];
    assign target = inst_q[25:0];

    logic [31:0] rs_val, rt_val, se_imm, ze_imm, pc4, br_tgt, j_tgt;

    assign rs_val = r[rs];
    assign rt_val = r[rt];
    assign se_imm = {{16{imm[15]}}, imm};
    assign ze_imm = {16'h0000, imm};
    assign pc4    = pc + 32'd4;
    assign br_tgt = pc4 + {se_imm[29:0], 2'b00};
    assign j_tgt  = {pc4[31:28], target, 2'b00};

    // Execute-stage decode results
    logic        ex_we;
    logic [4:0]  ex_wa;
    logic [31:0] ex_wd;
    logic [31:0] ex_pc;
    logic        is_lw, is_sw;
    logic [11:0] ls_addr;

    // Only the low 12 bits of the effective address reach the SRAM
    assign ls_addr = rs_val[11:0] + imm[11:0];

    // Decode the latched instruction into write-back, next-PC and memory intent
    always_comb begin
        ex_we = 1'b0;
        ex_wa = rt;
        ex_wd = '0;
        ex_pc = pc4;
        is_lw = 1'b0;
        is_sw = 1'b0;
        case (opcode)
            6'h00: begin
                ex_wa = rd;
                case (funct)
                    6'h00: begin ex_we = 1'b1; ex_wd = rs_val & rt_val; end
                    6'h01: begin ex_we = 1'b1; ex_wd = rs_val | rt_val; end
                    6'h02: begin ex_we = 1'b1; ex_wd = rs_val + rt_val; end
                    6'h03: begin ex_we = 1'b1; ex_wd = rs_val - rt_val; end
                    6'h04: begin
                        ex_we = 1'b1;
                        ex_wd = {31'd0, ($signed(rs_val) < $signed(rt_val))};
                    end
                    6'h05: begin ex_we = 1'b1; ex_wd = rt_val << shamt; end
                    6'h06: begin ex_we = 1'b1; ex_wd = ~(rs_val | rt_val); end
                    6'h07: ex_pc = rs_val;
`ifdef SP_MULT_EN
                    // Low word of a product is identical for signed and unsigned operands
                    6'h08: begin ex_we = 1'b1; ex_wd = rs_val * rt_val; end
`endif
                    default: ;
                endcase
            end
            6'h01: begin ex_we = 1'b1; ex_wd = rs_val & ze_imm; end
            6'h02: begin ex_we = 1'b1; ex_wd = rs_val | ze_imm; end
            6'h03: begin ex_we = 1'b1; ex_wd = rs_val + se_imm; end
            6'h04: begin ex_we = 1'b1; ex_wd = rs_val - se_imm; end
            6'h05: is_lw = 1'b1;
            6'h06: is_sw = 1'b1;
            6'h07: if (rs_val == rt_val) ex_pc = br_tgt;
            6'h08: if (rs_val != rt_val) ex_pc = br_tgt;
            6'h09: begin ex_we = 1'b1; ex_wd = {imm, 16'h0000}; end
            6'h0A: ex_pc = j_tgt;
            6'h0B: begin
                ex_pc = j_tgt;
                ex_we = 1'b1;
                ex_wa = 5'd31;
                ex_wd = pc4;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: memory ops detour through MEM (and WB for loads)
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (in_valid) state_nx = S_EXEC;
            S_EXEC: state_nx = (is_lw || is_sw) ? S_MEM : S_DONE;
            S_MEM:  state_nx = is_lw ? S_WB : S_DONE;
            S_WB:   state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values for the registered outputs, PC and register-file write port
    logic        ov_d, wen_d, rf_we;
    logic [31:0] ia_d, md_d, pc_d, inst_d, rf_wd;
    logic [11:0] ma_d;
    logic [4:0]  rf_wa;

    // Output logic: decide per state what is registered at the next edge
    always_comb begin
        ov_d   = 1'b0;
        ia_d   = inst_addr;
        wen_d  = 1'b1;
        ma_d   = mem_addr;
        md_d   = mem_din;
        pc_d   = pc;
        inst_d = inst_q;
        rf_we  = 1'b0;
        rf_wa  = ex_wa;
        rf_wd  = ex_wd;
        case (state)
            S_IDLE: if (in_valid) inst_d = inst;
            S_EXEC: begin
                pc_d = ex_pc;
                if (is_sw) begin
                    wen_d = 1'b0;
                    ma_d  = ls_addr;
                    md_d  = rt_val;
                end else if (is_lw) begin
                    ma_d = ls_addr;
                end else begin
                    rf_we = ex_we;
                    ov_d  = 1'b1;
                    ia_d  = ex_pc;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    ov_d = 1'b1;
                    ia_d = pc;
                end
            end
            S_WB: begin
                rf_we = 1'b1;
                rf_wa = rt;
                rf_wd = mem_dout;
                ov_d  = 1'b1;
                ia_d  = pc;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything so an in-flight op cannot complete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q    <= '0;
            pc        <= '0;
            out_valid <= 1'b0;
            inst_addr <= '0;
            mem_wen   <= 1'b1;
            mem_addr  <= '0;
            mem_din   <= '0;
            for (int unsigned i = 0; i < 32; i++) r[i] <= '0;
        end else begin
            inst_q    <= inst_d;
            pc        <= pc_d;
            out_valid <= ov_d;
            inst_addr <= ia_d;
            mem_wen   <= wen_d;
            mem_addr  <= ma_d;
            mem_din   <= md_d;
            if (rf_we && (rf_wa != 5'd0)) r[rf_wa] <= rf_wd;
        end
    end

endmodule

// File: tb/tb_simple_processor.sv
// Self-checking bench for simple_processor with a behavioural 4096x32 SRAM.
`timescale 1ns/1ps
module tb_simple_processor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] inst;
    logic [31:0] mem_dout;
    logic        out_valid;
    logic [31:0] inst_addr;
    logic        mem_wen;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;

    simple_processor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inst      (inst),
        .mem_dout  (mem_dout),
        .out_valid (out_valid),
        .inst_addr (inst_addr),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: read data appears one cycle after the address
    logic [31:0] sram [0:4095];
    always @(posedge clk) begin
        if (!mem_wen) sram[mem_addr] <= mem_din;
        mem_dout <= sram[mem_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] mpc;

    // Scoreboard: expected retirement pushed on issue, popped by the tests
    logic [31:0] exp_q [$];
    int          lat_q [$];
    logic [31:0] e_addr;
    int          e_lat;

    // Observations from the last issued instruction
    logic [31:0] obs_addr;
    int          obs_lat;
    int          wen_cnt, wen_lat;
    logic [11:0] wen_addr;
    logic [31:0] wen_din;
    logic        ov_after, wen_after;

    function automatic logic [31:0] rtype(input logic [4:0] s, t, d, sh, input logic [5:0] fn);
        return {6'h00, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tg);
        return {op, tg};
    endfunction

    // Drive one instruction, record expectations, and wait (bounded) for retirement
    task automatic issue(input logic [31:0] ins, input logic [31:0] exp_addr, input int exp_lat,
                         input bit use_junk, input logic [31:0] junk);
        int lat;
        bit seen;
        exp_q.push_back(exp_addr);
        lat_q.push_back(exp_lat);
        @(negedge clk);
        in_valid = 1'b1;
        inst     = ins;
        @(negedge clk);
        in_valid = use_junk;
        inst     = junk;
        lat = 1; seen = 0; wen_cnt = 0; wen_lat = 0; wen_addr = '0; wen_din = '0;
        while (!seen && lat <= 20) begin
            if (lat == 2) in_valid = 1'b0;
            if (mem_wen === 1'b0) begin
                wen_cnt++; wen_lat = lat; wen_addr = mem_addr; wen_din = mem_din;
            end
            if (out_valid === 1'b1) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        in_valid = 1'b0;
        if (seen) begin
            obs_addr = inst_addr;
            obs_lat  = lat;
        end else begin
            obs_addr = 'x;
            obs_lat  = -1;
        end
        @(negedge clk);
        ov_after  = out_valid;
        wen_after = mem_wen;
    endtask

    task automatic test_reset;
        int bad;
        rst_n = 1'b0; in_valid = 1'b0; inst = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || inst_addr !== 32'h0 || mem_wen !== 1'b1 ||
            mem_addr !== 12'h0 || mem_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ov=%b ia=%h wen=%b ma=%h md=%h, expected 0/0/1/0/0",
                     out_valid, inst_addr, mem_wen, mem_addr, mem_din);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (dut.r[i] !== 32'h0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_regs: %0d nonzero registers, expected 0", bad);
        end
        rst_n = 1'b1;
        @(negedge clk);
        mpc = 32'h0;
    endtask

    task automatic test_alu;
        logic [31:0] ti [14];
        logic [4:0]  tr [14];
        logic [31:0] tv [14];
        ti[0]  = 32'h0C010005;                    tr[0]  = 1;  tv[0]  = 32'd5;
        ti[1]  = itype(6'h03, 0, 2, 16'hFFFD);    tr[1]  = 2;  tv[1]  = 32'hFFFFFFFD;
        ti[2]  = rtype(1, 2, 3, 0, 6'h03);        tr[2]  = 3;  tv[2]  = 32'd8;
        ti[3]  = rtype(2, 1, 4, 0, 6'h04);        tr[3]  = 4;  tv[3]  = 32'd1;
        ti[4]  = rtype(0, 1, 5, 4, 6'h05);        tr[4]  = 5;  tv[4]  = 32'd80;
        ti[5]  = rtype(1, 2, 7, 0, 6'h06);        tr[5]  = 7;  tv[5]  = 32'd2;
        ti[6]  = itype(6'h09, 0, 8, 16'h1234);    tr[6]  = 8;  tv[6]  = 32'h12340000;
        ti[7]  = itype(6'h01, 2, 9, 16'hFFF0);    tr[7]  = 9;  tv[7]  = 32'h0000FFF0;
        ti[8]  = rtype(1, 2, 10, 0, 6'h02);       tr[8]  = 10; tv[8]  = 32'd2;
        ti[9]  = itype(6'h04, 1, 12, 16'h0007);   tr[9]  = 12; tv[9]  = 32'hFFFFFFFE;
        ti[10] = rtype(1, 2, 15, 0, 6'h01);       tr[10] = 15; tv[10] = 32'hFFFFFFFD;
        ti[11] = rtype(1, 2, 16, 0, 6'h00);       tr[11] = 16; tv[11] = 32'd5;
        ti[12] = itype(6'h02, 1, 17, 16'h8000);   tr[12] = 17; tv[12] = 32'h00008005;
        ti[13] = rtype(1, 2, 4, 0, 6'h04);        tr[13] = 4;  tv[13] = 32'd0;
        for (int i = 0; i < 14; i++) begin
            issue(ti[i], mpc + 32'd4, 2, 1'b0, 32'h0);
            mpc = mpc + 32'd4;
            e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
            checks++;
            if (obs_addr !== e_addr || obs_lat != e_lat) begin
                errors++;
                $display("FAIL alu_retire[%0d]: ia=%h lat=%0d, expected ia=%h lat=%0d",
                         i, obs_addr, obs_lat, e_addr, e_lat);
            end
            checks++;
            if (dut.r[tr[i]] !== tv[i]) begin
                errors++;
                $display("FAIL alu_result[%0d] r%0d: got %h, expected %h", i, tr[i], dut.r[tr[i]], tv[i]);
            end
            checks++;
            if (ov_after !== 1'b0) begin
                errors++;
                $display("FAIL alu_pulse[%0d]: out_valid after retire=%b, expected 0", i, ov_after);
            end
        end
    endtask

    task automatic test_mem;
        // sw r1,8(r0)
        issue(itype(6'h06, 0, 1, 16'h0008), mpc + 32'd4, 3, 1'b0, 32'h0);
        mpc = mpc + 32'd4;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        checks++;
        if (obs_addr !== e_addr || obs_lat != e_lat) begin
            errors++;
            $display("FAIL sw_retire: ia=%h lat=%0d, expected ia=%h lat=%0d", obs_addr, obs_lat, e_addr, e_lat);
        end
        checks++;
        if (wen_cnt != 1 || wen_lat != 2 || wen_addr !== 12'd8 || wen_din !== 32'd5 || wen_after !== 1'b1) begin
            errors++;
            $display("FAIL sw_port: cnt=%0d at=%0d addr=%h din=%h wen_after=%b, expected 1/2/008/00000005/1",
                     wen_cnt, wen_lat, wen_addr, wen_din, wen_after);
        end
        // lw r6,8(r0)
        issue(itype(6'h05, 0, 6, 16'h0008), mpc + 32'd4, 4, 1'b0, 32'h0);
        mpc = mpc + 32'd4;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        checks++;
        if (obs_addr !== e_addr || obs_lat != e_lat || wen_cnt != 0) begin
            errors++;
            $display("FAIL lw_retire: ia=%h lat=%0d writes=%0d, expected ia=%h lat=%0d writes=0",
                     obs_addr, obs_lat, wen_cnt, e_addr, e_lat);
        end
        checks++;
        if (dut.r[6] !== 32'd5) begin
            errors++;
            $display("FAIL lw_data r6: got %h, expected 00000005", dut.r[6]);
        end
        // lw r14,3(r1) -> address 8
        issue(itype(6'h05, 1, 14, 16'h0003), mpc + 32'd4, 4, 1'b0, 32'h0);
        mpc = mpc + 32'd4;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        checks++;
        if (obs_addr !== e_addr || obs_lat != e_lat || dut.r[14] !== 32'd5) begin
            errors++;
            $display("FAIL lw_base r14: got %h ia=%h lat=%0d, expected 00000005 ia=%h lat=%0d",
                     dut.r[14], obs_addr, obs_lat, e_addr, e_lat);
        end
        // sw r8,-6(r1): 5-6 wraps to 12-bit address 0xFFF
        issue(itype(6'h06, 1, 8, 16'hFFFA), mpc + 32'd4, 3, 1'b0, 32'h0);
        mpc = mpc + 32'd4;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        checks++;
        if (obs_addr !== e_addr || wen_addr !== 12'hFFF || wen_din !== 32'h12340000) begin
            errors++;
            $display("FAIL sw_wrap: ia=%h addr=%h din=%h, expected ia=%h addr=fff din=12340000",
                     obs_addr, wen_addr, wen_din, e_addr);
        end
        // lw r19,0xFFF(r0)
        issue(itype(6'h05, 0, 19, 16'h0FFF), mpc + 32'd4, 4, 1'b0, 32'h0);
        mpc = mpc + 32'd4;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        checks++;
        if (obs_addr !== e_addr || dut.r[19] !== 32'h12340000) begin
            errors++;
            $display("FAIL lw_wrap r19: got %h ia=%h, expected 12340000 ia=%h", dut.r[19], obs_addr, e_addr);
        end
    endtask

    task automatic test_branch;
        logic [31:0] ins [4];
        logic [31:0] nxt [4];
        ins[0] = itype(6'h07, 1, 1, 16'hFFFE);  // beq taken, -2
        ins[1] = itype(6'h08, 1, 1, 16'h0003);  // bne not taken
        ins[2] = itype(6'h08, 1, 2, 16'h0003);  // bne taken, +3
        ins[3] = itype(6'h07, 1, 2, 16'h0005);  // beq not taken
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: nxt[i] = mpc - 32'd4;
                2: nxt[i] = mpc + 32'd16;
                default: nxt[i] = mpc + 32'd4;
            endcase
            issue(ins[i], nxt[i], 2, 1'b0, 32'h0);
            mpc = nxt[i];
            e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
            checks++;
            if (obs_addr !== e_addr || obs_lat != e_lat) begin
                errors++;
                $display("FAIL branch[%0d]: ia=%h lat=%0d, expected ia=%h lat=%0d",
                         i, obs_addr, obs_lat, e_addr, e_lat);
            end
        end
    endtask

    task automatic test_jump;
        logic [31:0] link;
        link = mpc + 32'd4;
        issue(jtype(6'h0B, 26'h40), 32'h100, 2, 1'b0, 32'h0);
        mpc = 32'h100;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        checks++;
        if (obs_addr !== e_addr || dut.r[31] !== link) begin
            errors++;
            $display("FAIL jal: ia=%h r31=%h, expected ia=%h r31=%h", obs_addr, dut.r[31], e_addr, link);
        end
        issue(rtype(31, 0, 0, 0, 6'h07), link, 2, 1'b0, 32'h0);
        mpc = link;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        checks++;
        if (obs_addr !== e_addr || obs_lat != e_lat) begin
            errors++;
            $display("FAIL jr: ia=%h lat=%0d, expected ia=%h lat=%0d", obs_addr, obs_lat, e_addr, e_lat);
        end
        issue(jtype(6'h0A, 26'h20), 32'h80, 2, 1'b0, 32'h0);
        mpc = 32'h80;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        checks++;
        if (obs_addr !== e_addr) begin
            errors++;
            $display("FAIL j: ia=%h, expected ia=%h", obs_addr, e_addr);
        end
    endtask

    task automatic test_nop_cases;
        logic [31:0] snap [32];
        int diffs;
        logic [31:0] exp_r11;
        // addi r0,r0,7
        issue(itype(6'h03, 0, 0, 16'h0007), mpc + 32'd4, 2, 1'b0, 32'h0);
        mpc = mpc + 32'd4;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        checks++;
        if (obs_addr !== e_addr || dut.r[0] !== 32'h0) begin
            errors++;
            $display("FAIL r0_write: r0=%h ia=%h, expected 00000000 ia=%h", dut.r[0], obs_addr, e_addr);
        end
        // undefined opcode 0x3F and undefined funct 0x3F
        for (int i = 0; i < 32; i++) snap[i] = dut.r[i];
        issue(32'hFC000000, mpc + 32'd4, 2, 1'b0, 32'h0);
        mpc = mpc + 32'd4;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        issue(rtype(1, 2, 20, 0, 6'h3F), mpc + 32'd4, 2, 1'b0, 32'h0);
        mpc = mpc + 32'd4;
        diffs = 0;
        for (int i = 0; i < 32; i++) if (dut.r[i] !== snap[i]) diffs++;
        checks++;
        if (obs_lat != 2 || diffs != 0) begin
            errors++;
            $display("FAIL undefined_nop: lat=%0d reg_changes=%0d, expected lat=2 reg_changes=0", obs_lat, diffs);
        end
        checks++;
        if (exp_q.pop_front() !== obs_addr) begin
            errors++;
            $display("FAIL undefined_pc: ia=%h, expected ia=%h", obs_addr, mpc);
        end
        void'(lat_q.pop_front());
        // funct 0x08: mult when enabled, otherwise NOP
`ifdef SP_MULT_EN
        exp_r11 = 32'hFFFFFFF1;
`else
        exp_r11 = 32'h0;
`endif
        issue(rtype(1, 2, 11, 0, 6'h08), mpc + 32'd4, 2, 1'b0, 32'h0);
        mpc = mpc + 32'd4;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        checks++;
        if (obs_addr !== e_addr || dut.r[11] !== exp_r11) begin
            errors++;
            $display("FAIL funct08 r11: got %h ia=%h, expected %h ia=%h", dut.r[11], obs_addr, exp_r11, e_addr);
        end
    endtask

    task automatic test_busy_ignore;
        int extra;
        // addi r21,r0,1 with a competing addi r13,r0,9 offered while busy
        issue(itype(6'h03, 0, 21, 16'h0001), mpc + 32'd4, 2, 1'b1, itype(6'h03, 0, 13, 16'h0009));
        mpc = mpc + 32'd4;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra++;
        end
        checks++;
        if (obs_addr !== e_addr || dut.r[21] !== 32'd1) begin
            errors++;
            $display("FAIL busy_main: r21=%h ia=%h, expected 00000001 ia=%h", dut.r[21], obs_addr, e_addr);
        end
        checks++;
        if (extra != 0 || dut.r[13] !== 32'h0) begin
            errors++;
            $display("FAIL busy_ignore: extra_retires=%0d r13=%h, expected 0 00000000", extra, dut.r[13]);
        end
    endtask

    task automatic test_reset_mid_lw;
        int extra;
        @(negedge clk);
        in_valid = 1'b1;
        inst     = itype(6'h05, 0, 22, 16'h0008);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_addr !== 12'd8 || mem_wen !== 1'b1) begin
            errors++;
            $display("FAIL midlw_addr: ma=%h wen=%b, expected 008 1", mem_addr, mem_wen);
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || inst_addr !== 32'h0 || mem_wen !== 1'b1 ||
            mem_addr !== 12'h0 || mem_din !== 32'h0 || dut.r[22] !== 32'h0) begin
            errors++;
            $display("FAIL midlw_reset: ov=%b ia=%h wen=%b ma=%h md=%h r22=%h, expected 0/0/1/0/0/0",
                     out_valid, inst_addr, mem_wen, mem_addr, mem_din, dut.r[22]);
        end
        rst_n = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid === 1'b1 || mem_wen === 1'b0) extra++;
        end
        checks++;
        if (extra != 0 || dut.r[22] !== 32'h0) begin
            errors++;
            $display("FAIL midlw_abort: activity=%0d r22=%h, expected 0 00000000", extra, dut.r[22]);
        end
        mpc = 32'h0;
        issue(32'h0C010005, 32'd4, 2, 1'b0, 32'h0);
        mpc = 32'd4;
        e_addr = exp_q.pop_front(); e_lat = lat_q.pop_front();
        checks++;
        if (obs_addr !== e_addr || obs_lat != e_lat || dut.r[1] !== 32'd5) begin
            errors++;
            $display("FAIL post_reset: ia=%h lat=%0d r1=%h, expected ia=%h lat=%0d r1=00000005",
                     obs_addr, obs_lat, dut.r[1], e_addr, e_lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_jump();
        test_nop_cases();
        test_busy_ignore();
        test_reset_mid_lw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
